// File: rtl/lr2_pkg.sv
// Shared types and default parameters for the LR2 button/prescaler controller.
// Holds the debounce FSM state type used by every lr2_debounce instance.
package lr2_pkg;

    localparam int unsigned DivDefault      = 8;
    localparam int unsigned DbCyclesDefault = 4;

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } db_state_e;

endpackage

// File: rtl/lr2_debounce.sv
// Two-flop synchronizer plus debounce FSM for one raw button.
// Emits a single-cycle press pulse when a press is accepted; releases are silent.
module lr2_debounce
    import lr2_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic btn,
    output logic press
);

    localparam int unsigned    CntW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    db_state_e       state_q;
    db_state_e       state_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            cnt_done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StReleased;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_done = (cnt_q == CntLast);

    // The counter tallies consecutive samples at the new level while waiting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StReleased: begin
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = StPressWait;
                end
            end
            StPressWait: begin
                if (!sync2_q) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = StReleaseWait;
                end
            end
            StReleaseWait: begin
                if (sync2_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press = (state_q == StPressWait) && sync2_q && cnt_done;
    end

endmodule

// File: rtl/lr2_ctrl.sv
// Front-panel controller: debounced load/direction/run buttons driving a
// downstream counter through registered LOAD/DAT_I/UP/RUN and a CE prescaler.
module lr2_ctrl
    import lr2_pkg::*;
#(
    parameter int unsigned DIV       = DivDefault,
    parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_LOAD,
    input  logic       BTN_DIR,
    input  logic       BTN_RUN,
    input  logic [3:0] SW_DAT,
    output logic       CE,
    output logic       LOAD,
    output logic [3:0] DAT_I,
    output logic       UP,
    output logic       RUN
);

    localparam int unsigned     PsW    = $clog2(DIV);
    localparam logic [PsW-1:0]  PsLast = PsW'(DIV - 1);

    logic [3:0]     sw_sync1_q;
    logic [3:0]     sw_sync2_q;
    logic           press_load;
    logic           press_dir;
    logic           press_run;
    logic [PsW-1:0] ps_q;
    logic [PsW-1:0] ps_d;
    logic           ce_q;
    logic           ce_d;
    logic           load_q;
    logic           load_d;
    logic [3:0]     dat_q;
    logic [3:0]     dat_d;
    logic           up_q;
    logic           up_d;
    logic           run_q;
    logic           run_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= SW_DAT;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    lr2_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_load (
        .CLK   (CLK),
        .RST_N (RST_N),
        .btn   (BTN_LOAD),
        .press (press_load)
    );

    lr2_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_dir (
        .CLK   (CLK),
        .RST_N (RST_N),
        .btn   (BTN_DIR),
        .press (press_dir)
    );

    lr2_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_run (
        .CLK   (CLK),
        .RST_N (RST_N),
        .btn   (BTN_RUN),
        .press (press_run)
    );

    always_comb begin
        load_d = press_load;
        dat_d  = press_load ? sw_sync2_q : dat_q;
        up_d   = up_q ^ press_dir;
        run_d  = run_q ^ press_run;
    end

    // Counting only while RUN is set now and stays set, so a stopping edge
    // can never emit a CE and a starting edge begins a full period from 0.
    always_comb begin
        ps_d = ps_q + 1'b1;
        ce_d = 1'b0;
        if (press_load || !run_q || !run_d) begin
            ps_d = '0;
        end else if (ps_q == PsLast) begin
            ps_d = '0;
            ce_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps_q   <= '0;
            ce_q   <= 1'b0;
            load_q <= 1'b0;
            dat_q  <= '0;
            up_q   <= 1'b1;
            run_q  <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            ce_q   <= ce_d;
            load_q <= load_d;
            dat_q  <= dat_d;
            up_q   <= up_d;
            run_q  <= run_d;
        end
    end

    assign CE    = ce_q;
    assign LOAD  = load_q;
    assign DAT_I = dat_q;
    assign UP    = up_q;
    assign RUN   = run_q;

endmodule

// File: tb/tb_lr2_ctrl.sv
// Scoreboard bench for lr2_ctrl: a cycle-level behavioural model pushes the
// expected outputs after every edge; a monitor pops and compares on the falling edge.
module tb_lr2_ctrl;

    localparam int unsigned DIV = 8;
    localparam int unsigned DB  = 4;

    typedef struct packed {
        logic       ce;
        logic       load;
        logic [3:0] dat;
        logic       up;
        logic       run;
    } exp_t;

    logic       CLK;
    logic       RST_N;
    logic       BTN_LOAD;
    logic       BTN_DIR;
    logic       BTN_RUN;
    logic [3:0] SW_DAT;
    logic       CE;
    logic       LOAD;
    logic [3:0] DAT_I;
    logic       UP;
    logic       RUN;

    int n_checks = 0;
    int n_err    = 0;

    lr2_ctrl #(
        .DIV       (DIV),
        .DB_CYCLES (DB)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_LOAD (BTN_LOAD),
        .BTN_DIR  (BTN_DIR),
        .BTN_RUN  (BTN_RUN),
        .SW_DAT   (SW_DAT),
        .CE       (CE),
        .LOAD     (LOAD),
        .DAT_I    (DAT_I),
        .UP       (UP),
        .RUN      (RUN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the end of the test");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: raw samples seen two edges late, and for each
    // button the accepted level plus the length of the current run of samples
    // that disagree with it. A change is accepted after DB+1 such samples.
    exp_t       sb[$];
    exp_t       e;
    logic [2:0] raw_d1, raw_d2, seen, press, acc;
    logic [3:0] sw_d1, sw_d2, sw_seen;
    int         runlen[3];
    logic       m_ce, m_load, m_up, m_run, new_run;
    logic [3:0] m_dat;
    int         ph;

    task automatic model_reset();
        raw_d1 = '0;
        raw_d2 = '0;
        sw_d1  = '0;
        sw_d2  = '0;
        acc    = '0;
        for (int b = 0; b < 3; b++) runlen[b] = 0;
        m_ce   = 1'b0;
        m_load = 1'b0;
        m_dat  = '0;
        m_up   = 1'b1;
        m_run  = 1'b0;
        ph     = 0;
    endtask

    initial model_reset();

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            model_reset();
            sb.delete();
        end else begin
            seen    = raw_d2;
            sw_seen = sw_d2;
            raw_d2  = raw_d1;
            sw_d2   = sw_d1;
            raw_d1  = {BTN_RUN, BTN_DIR, BTN_LOAD};
            sw_d1   = SW_DAT;
            for (int b = 0; b < 3; b++) begin
                press[b] = 1'b0;
                if (seen[b] != acc[b]) begin
                    runlen[b]++;
                    if (runlen[b] == DB + 1) begin
                        acc[b]    = seen[b];
                        runlen[b] = 0;
                        press[b]  = seen[b];
                    end
                end else begin
                    runlen[b] = 0;
                end
            end
            new_run = m_run ^ press[2];
            if (press[1]) m_up = ~m_up;
            m_load = press[0];
            if (press[0]) m_dat = sw_seen;
            // ph counts edges since the CE phase (re)started.
            if (press[0] || !m_run || !new_run) begin
                ph   = 0;
                m_ce = 1'b0;
            end else begin
                ph++;
                m_ce = ((ph % DIV) == 0);
            end
            m_run = new_run;
            sb.push_back('{ce: m_ce, load: m_load, dat: m_dat, up: m_up, run: m_run});
        end
    end

    always @(negedge CLK) begin
        if (RST_N && sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_ce",   32'(CE),    32'(e.ce));
            check("sb_load", 32'(LOAD),  32'(e.load));
            check("sb_dat",  32'(DAT_I), 32'(e.dat));
            check("sb_up",   32'(UP),    32'(e.up));
            check("sb_run",  32'(RUN),   32'(e.run));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce"},   32'(CE),    32'd0);
        check({tag, "_load"}, 32'(LOAD),  32'd0);
        check({tag, "_dat"},  32'(DAT_I), 32'd0);
        check({tag, "_up"},   32'(UP),    32'd1);
        check({tag, "_run"},  32'(RUN),   32'd0);
    endtask

    task automatic wait_run(input logic lvl, input int budget);
        int n;
        n = 0;
        while (RUN !== lvl && n < budget) begin
            tick();
            n++;
        end
        check("run_wait", 32'(RUN), 32'(lvl));
    endtask

    task automatic cycles_to_ce(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (CE !== 1'b1 && n < budget);
    endtask

    int n;
    int ce_cnt;
    int hold[3];

    initial begin
        RST_N    = 1'b1;
        BTN_LOAD = 1'b0;
        BTN_DIR  = 1'b0;
        BTN_RUN  = 1'b0;
        SW_DAT   = 4'h0;
        #1 RST_N = 1'b0;
        #1 check_reset_outputs("rst_noclk");
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        tick();

        // Held load button: one pulse after edge DB+2, carrying the switches.
        SW_DAT   = 4'hA;
        BTN_LOAD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("load_pulse", 32'(LOAD), 32'(i == 6));
            if (i == 6) check("load_dat", 32'(DAT_I), 32'hA);
        end
        check("dat_hold", 32'(DAT_I), 32'hA);
        BTN_LOAD = 1'b0;
        repeat (12) tick();

        // Bouncing direction button, then stable.
        for (int r = 0; r < 10; r++) begin
            BTN_DIR = 1'b1;
            repeat (3) tick();
            BTN_DIR = 1'b0;
            tick();
        end
        check("up_bounce", 32'(UP), 32'd1);
        BTN_DIR = 1'b1;
        repeat (10) tick();
        check("up_toggle", 32'(UP), 32'd0);
        BTN_DIR = 1'b0;
        repeat (12) tick();
        check("up_release", 32'(UP), 32'd0);

        // Start running: CE period measured from RUN rising.
        BTN_RUN = 1'b1;
        wait_run(1'b1, 20);
        cycles_to_ce(20, n);
        check("ce_first", 32'(n), 32'(DIV));
        cycles_to_ce(20, n);
        check("ce_period", 32'(n), 32'(DIV));
        BTN_RUN = 1'b0;
        repeat (10) tick();

        // Load with the prescaler holding 5 on the load edge.
        cycles_to_ce(20, n);
        check("ce_found", 32'(CE), 32'd1);
        repeat (7) tick();
        BTN_LOAD = 1'b1;
        n = 0;
        while (LOAD !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("load_run", 32'(LOAD), 32'd1);
        check("load_no_ce", 32'(CE), 32'd0);
        cycles_to_ce(20, n);
        check("ce_after_load", 32'(n), 32'(DIV));
        BTN_LOAD = 1'b0;
        repeat (12) tick();

        // Stop: no CE once RUN is low.
        BTN_RUN = 1'b1;
        wait_run(1'b0, 20);
        ce_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) BTN_RUN = 1'b0;
            if (CE) ce_cnt++;
            tick();
        end
        check("ce_stopped", 32'(ce_cnt), 32'd0);

        // Restart, then drop reset between edges.
        BTN_RUN = 1'b1;
        wait_run(1'b1, 20);
        BTN_RUN = 1'b0;
        repeat (11) tick();
        #1 RST_N = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        ce_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (CE) ce_cnt++;
        end
        check("ce_after_rst", 32'(ce_cnt), 32'd0);
        check("run_after_rst", 32'(RUN), 32'd0);

        // Randomised bouncy buttons and switches, checked by the scoreboard.
        for (int b = 0; b < 3; b++) hold[b] = $urandom_range(1, 12);
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                hold[b]--;
                if (hold[b] == 0) begin
                    hold[b] = $urandom_range(1, 12);
                    unique case (b)
                        0: BTN_LOAD = ~BTN_LOAD;
                        1: BTN_DIR  = ~BTN_DIR;
                        default: BTN_RUN = ~BTN_RUN;
                    endcase
                end
            end
            if ($urandom_range(0, 3) == 0) SW_DAT = 4'($urandom_range(0, 15));
            tick();
        end
        BTN_LOAD = 1'b0;
        BTN_DIR  = 1'b0;
        BTN_RUN  = 1'b0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
